load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit of the RV32I pipeline; consumes the control unit's memory-side outputs (MemRW, load indication, fund3) and the ALU address, and drives a request/acknowledge data-memory bus. It formats byte lanes for SB/SH/SW, sign- or zero-extends LB/LH/LW/LBU/LHU results, and stalls the pipeline until the memory acknowledges. Misaligned or undefined accesses are rejected without a bus transaction.

## Interface
- XLEN, 32, data/address width (only 32 supported)
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- MemRW  in  1  store request (1 = store)
- MemRd  in  1  load request (driven from the control unit's Load_Hazard)
- fund3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2)
- stall  out  1  hold IF/ID/EX/MEM pipeline registers
- rdata  out  32  extended load result for writeback
- err  out  1  one-cycle pulse: misaligned or undefined access
- mem_req  out  1  bus request, registered
- mem_we  out  1  bus write enable
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-formatted store data
- mem_ack  in  1  bus completion, one cycle per request
- mem_rdata  in  32  read word, valid with mem_ack

## Operation
- States: IDLE, BUSY, DONE.
- access = MemRW | MemRd; MemRW has priority if both set (store performed, load ignored).
- IDLE, access, legal: stall=1 (combinational); latch we, be, word address, formatted wdata, fund3, addr[1:0]; next BUSY.
- IDLE, access, illegal: err=1 for that cycle, stall=0, no bus request, rdata=0; stay IDLE.
- Illegal: H/HU with addr[0]=1; W with addr[1:0]≠00; fund3 ∈ {011,110,111}; stores with fund3 ∈ {100,101}.
- BUSY: mem_req=1, stall=1; on mem_ack capture extended mem_rdata into rdata register; next DONE.
- DONE: mem_req=0, stall=0, rdata valid (loads); pipeline advances at end of cycle; next IDLE.
- Store lanes: SB be=0001<<addr[1:0], data byte replicated ×4; SH be=0011<<addr[1:0], halfword replicated ×2; SW be=1111.
- Load extraction: byte at lane addr[1:0], halfword at addr[1]; B/H sign-extend bit 7/15, BU/HU zero-extend; W passes through.
- For stores rdata holds its previous value.
- mem_ack outside BUSY is ignored.

## Timing
- Reset: state IDLE; mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rdata=0, err=0; stall=0.
- rst asserted mid-BUSY: mem_req drops immediately (asynchronous); pending ack after release is ignored.
- mem_req first high the cycle after the access enters IDLE; held until the ack cycle inclusive.
- Minimum access (ack in first BUSY cycle): 3 cycles, stall high 2 cycles; each extra wait cycle adds one.
- rdata updates at the ack edge, stable through DONE and until the next load completes.
- Back-to-back accesses: a new access is only accepted in IDLE; DONE always inserts one non-stalled cycle.
- Bus outputs (mem_we, mem_be, mem_addr, mem_wdata) are stable for the entire BUSY period.

## Structure
- Shared package: fund3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU), state encoding, XLEN.
- Sub-module lsu_lane_fmt: combinational store-lane formatter and load extractor/extender; the FSM and registers live in load_store_unit.

## Test plan
- SW addr=0x100, wdata=0xDEADBEEF, ack after 2 wait cycles -> mem_addr=0x100, be=1111, mem_we=1, stall high 4 cycles, err=0.
- SB addr=0x203, wdata=0x000000A5 -> be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x200.
- LB addr=0x301, mem_rdata=0x00008000... use 0x0000F000 -> rdata=0xFFFFFFF0; LBU same -> 0x000000F0; LHU addr=0x302, mem_rdata=0x8001xxxx -> 0x00008001.
- LW addr=0x102 -> err pulse 1 cycle, mem_req stays 0, stall 0; fund3=011 load -> same.
- rst asserted in BUSY before ack -> mem_req=0 same cycle, rdata=0; late mem_ack after release ignored, state IDLE.
- MemRW=MemRd=1 SH addr=0x10 -> store issued (mem_we=1, be=0011), rdata unchanged.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the RV32I memory-stage load/store unit:
// access encodings, FSM states and the access legality rule.
package load_store_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_t;

  // Alignment and encoding check; unsigned sizes exist only for loads.
  function automatic logic access_legal(input logic       is_store,
                                        input logic [2:0] f3,
                                        input logic [1:0] lo);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !is_store;
      F3_H:    ok = !lo[0];
      F3_HU:   ok = !is_store && !lo[0];
      F3_W:    ok = (lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Combinational byte-lane logic: store data/enable formatting and
// load extraction with sign or zero extension.
module lsu_lane_fmt
  import load_store_unit_pkg::*;
(
  input  logic [2:0]      i_st_f3,
  input  logic [1:0]      i_st_lo,
  input  logic [XLEN-1:0] i_st_data,
  output logic [3:0]      o_st_be,
  output logic [XLEN-1:0] o_st_wdata,
  input  logic [2:0]      i_ld_f3,
  input  logic [1:0]      i_ld_lo,
  input  logic [XLEN-1:0] i_ld_word,
  output logic [XLEN-1:0] o_ld_data
);

  logic [XLEN-1:0] w_shifted;

  // Store formatting keyed on access size only (f3[1:0]).
  always_comb begin
    o_st_be    = 4'b1111;
    o_st_wdata = i_st_data;
    case (i_st_f3[1:0])
      2'b00: begin
        o_st_be    = 4'b0001 << i_st_lo;
        o_st_wdata = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        o_st_be    = 4'b0011 << i_st_lo;
        o_st_wdata = {2{i_st_data[15:0]}};
      end
      default: begin
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_data;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend.
  always_comb begin
    w_shifted = i_ld_word >> {i_ld_lo, 3'b000};
    case (i_ld_f3)
      F3_B:    o_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_BU:   o_ld_data = {24'h000000, w_shifted[7:0]};
      F3_H:    o_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_HU:   o_ld_data = {16'h0000, w_shifted[15:0]};
      default: o_ld_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: accepts one access in IDLE, runs a
// request/acknowledge bus transaction, and stalls the pipeline until done.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            MemRW,
  input  logic            MemRd,
  input  logic [2:0]      fund3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic [XLEN-1:0] rdata,
  output logic            err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t      r_state;
  lsu_state_t      w_next;
  logic            w_access;
  logic            w_legal;
  logic            w_start;
  logic [3:0]      w_st_be;
  logic [XLEN-1:0] w_st_wdata;
  logic [XLEN-1:0] w_ld_data;
  logic [2:0]      r_f3;
  logic [1:0]      r_lo;
  logic [XLEN-1:0] r_rdata;

  // A simultaneous store and load request is treated as a store.
  assign w_access = MemRW | MemRd;
  assign w_legal  = access_legal(MemRW, fund3, addr[1:0]);

  lsu_lane_fmt u_lane_fmt (
    .i_st_f3    (fund3),
    .i_st_lo    (addr[1:0]),
    .i_st_data  (wdata),
    .o_st_be    (w_st_be),
    .o_st_wdata (w_st_wdata),
    .i_ld_f3    (r_f3),
    .i_ld_lo    (r_lo),
    .i_ld_word  (mem_rdata),
    .o_ld_data  (w_ld_data)
  );

  always_comb begin
    w_next  = r_state;
    stall   = 1'b0;
    err     = 1'b0;
    w_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access && w_legal) begin
          stall   = 1'b1;
          w_start = 1'b1;
          w_next  = ST_BUSY;
        end else if (w_access) begin
          err = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (mem_ack) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_BUSY;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
      r_f3      <= 3'b000;
      r_lo      <= 2'b00;
      r_rdata   <= '0;
    end else begin
      r_state <= w_next;
      mem_req <= (w_next == ST_BUSY);
      if (w_start) begin
        mem_we    <= MemRW;
        mem_be    <= w_st_be;
        mem_addr  <= {addr[XLEN-1:2], 2'b00};
        mem_wdata <= w_st_wdata;
        r_f3      <= fund3;
        r_lo      <= addr[1:0];
      end
      // Stores leave the previous load result in place.
      if (r_state == ST_BUSY && mem_ack && !mem_we) begin
        r_rdata <= w_ld_data;
      end
    end
  end

  assign rdata = err ? '0 : r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a
// behavioural model of the access rules.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRW, MemRd;
  logic [2:0]  fund3;
  logic [31:0] addr, wdata;
  logic        stall, err, mem_req, mem_we, mem_ack;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_rdata = 32'h0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .MemRW(MemRW), .MemRd(MemRd), .fund3(fund3),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    MemRW = 1'b0; MemRd = 1'b0; fund3 = 3'b000; addr = 32'h0; wdata = 32'h0;
  endtask

  function automatic bit model_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int size;
    if (st && f3 > 3'd2) return 1'b0;
    if (!st && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    size = 1 << f3[1:0];
    return (a % size) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] s, v;
    s = w >> (8 * a[1:0]);
    if (f3[1:0] == 2'd0) begin
      v = s & 32'hFF;
      if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
    end else if (f3[1:0] == 2'd1) begin
      v = s & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic run_access(input bit rw, input bit rd, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] word, input int waits, input bit ack_in_done);
    bit st;
    int nbytes, stalls;
    logic [3:0] e_be;
    logic [31:0] e_wd;
    st = rw;
    nbytes = 1 << f3[1:0];
    e_be = 4'(((1 << nbytes) - 1) << a[1:0]);
    if (nbytes == 1)      e_wd = {24'h0, wd[7:0]} * 32'h01010101;
    else if (nbytes == 2) e_wd = {16'h0, wd[15:0]} * 32'h00010001;
    else                  e_wd = wd;

    @(posedge clk); #1;
    MemRW = rw; MemRd = rd; fund3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    if (!model_legal(st, f3, a)) begin
      chk("err_pulse", {31'h0, err}, 32'd1);
      chk("err_stall", {31'h0, stall}, 32'd0);
      chk("err_req", {31'h0, mem_req}, 32'd0);
      chk("err_rdata", rdata, 32'h0);
      @(posedge clk); #1; idle_inputs();
      @(negedge clk);
      chk("err_drop", {31'h0, err}, 32'd0);
      chk("err_noreq", {31'h0, mem_req}, 32'd0);
      return;
    end
    chk("acc_err", {31'h0, err}, 32'd0);
    chk("acc_stall", {31'h0, stall}, 32'd1);
    chk("acc_req_early", {31'h0, mem_req}, 32'd0);
    stalls = 1;
    for (int w = 0; w <= waits; w++) begin
      @(negedge clk);
      stalls += int'(stall);
      chk("busy_req", {31'h0, mem_req}, 32'd1);
      chk("busy_we", {31'h0, mem_we}, {31'h0, st});
      chk("busy_addr", mem_addr, a & 32'hFFFF_FFFC);
      if (st) begin
        chk("busy_be", {28'h0, mem_be}, {28'h0, e_be});
        chk("busy_wdata", mem_wdata, e_wd);
      end
      if (w == waits) begin
        mem_ack = 1'b1; mem_rdata = word;
      end
    end
    if (!st) exp_rdata = model_load(f3, a, word);
    @(posedge clk); #1;
    mem_ack = ack_in_done; mem_rdata = $urandom;
    @(negedge clk);
    chk("done_stall", {31'h0, stall}, 32'd0);
    chk("done_req", {31'h0, mem_req}, 32'd0);
    chk("done_rdata", rdata, exp_rdata);
    chk("stall_cycles", stalls, waits + 2);
    @(posedge clk); #1;
    mem_ack = 1'b0; idle_inputs();
    @(negedge clk);
    chk("idle_rdata", rdata, exp_rdata);
    chk("idle_req", {31'h0, mem_req}, 32'd0);
  endtask

  initial begin
    bit          rrw, rrd;
    int          sel;
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
    idle_inputs();
    #12;
    chk("rst_req", {31'h0, mem_req}, 32'd0);
    chk("rst_we", {31'h0, mem_we}, 32'd0);
    chk("rst_be", {28'h0, mem_be}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", {31'h0, err}, 32'd0);
    chk("rst_stall", {31'h0, stall}, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2, 1'b0);
    run_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h000000A5, 32'h0, 0, 1'b0);
    run_access(1'b0, 1'b1, 3'b000, 32'h301, 32'h0, 32'h0000F000, 0, 1'b1);
    chk("lb_val", rdata, 32'hFFFFFFF0);
    run_access(1'b0, 1'b1, 3'b100, 32'h301, 32'h0, 32'h0000F000, 1, 1'b0);
    chk("lbu_val", rdata, 32'h000000F0);
    run_access(1'b0, 1'b1, 3'b101, 32'h302, 32'h0, 32'h80011234, 0, 1'b0);
    chk("lhu_val", rdata, 32'h00008001);
    run_access(1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 32'h0, 0, 1'b0);
    run_access(1'b0, 1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1'b0);
    run_access(1'b1, 1'b1, 3'b001, 32'h10, 32'h0000BEEF, 32'h12345678, 0, 1'b0);
    chk("both_keep", rdata, 32'h00008001);

    // Reset while BUSY, then a stale acknowledge after release.
    @(posedge clk); #1;
    MemRW = 1'b0; MemRd = 1'b1; fund3 = 3'b010; addr = 32'h40;
    @(negedge clk);
    @(negedge clk);
    chk("rb_req", {31'h0, mem_req}, 32'd1);
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    chk("rb_req_drop", {31'h0, mem_req}, 32'd0);
    chk("rb_rdata", rdata, 32'h0);
    chk("rb_stall", {31'h0, stall}, 32'd0);
    exp_rdata = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("late_ack_req", {31'h0, mem_req}, 32'd0);
    chk("late_ack_stall", {31'h0, stall}, 32'd0);
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_rdata", rdata, 32'h0);
    chk("late_ack_idle", {31'h0, mem_req}, 32'd0);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(1, 3);
      rrw = sel[0]; rrd = sel[1];
      run_access(rrw, rrd, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
